// File: rtl/tc_accum_sequencer_pkg.sv
// Shared constants for the tensorcore accumulation sequencer: tile geometry
// and the FSM state encoding.
package tc_accum_sequencer_pkg;

  localparam int TC_DW  = 256;
  localparam int LANE_W = 16;
  localparam int LANES  = TC_DW / LANE_W;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ISSUE  = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_RESULT = 2'd3;

endpackage

// File: rtl/tc_accum_sequencer_watchdog.sv
// Cycle counter bounding how long the sequencer waits for a tensorcore result;
// expire flags the cycle whose increment would bring the count to TIMEOUT.
module tc_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expire = en && !clr && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/tc_accum_sequencer.sv
// Drives one tensorcore through a K-step accumulation, feeding each result back
// as the next step's C operand, and returns the final tile.
module tc_accum_sequencer
  import tc_accum_sequencer_pkg::*;
#(
  parameter int DW      = TC_DW,
  parameter int KW      = 8,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [KW-1:0] cmd_k,
  input  logic          cmd_e5m2,
  input  logic [DW-1:0] cmd_c,
  input  logic          ab_valid,
  output logic          ab_ready,
  input  logic [DW-1:0] ab_a,
  input  logic [DW-1:0] ab_b,
  output logic          tc_in_valid,
  output logic          tc_e5m2mode,
  output logic [DW-1:0] tc_a,
  output logic [DW-1:0] tc_b,
  output logic [DW-1:0] tc_c,
  input  logic          tc_out_valid,
  input  logic [DW-1:0] tc_d,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_d,
  output logic          busy,
  output logic          err
);

  logic [1:0]    state;
  logic [1:0]    state_nx;
  logic [KW-1:0] k_reg;
  logic [KW-1:0] step_cnt;
  logic [DW-1:0] acc;
  logic          quiet;
  logic          cmd_fire;
  logic          ab_fire;
  logic          res_fire;
  logic          last_step;
  logic          stray;
  logic          wd_en;
  logic          wd_clr;
  logic          wd_expire;

  assign cmd_fire  = cmd_valid && cmd_ready;
  assign ab_fire   = ab_valid && ab_ready;
  assign res_fire  = res_valid && res_ready;
  assign last_step = (step_cnt == k_reg);
  assign stray     = tc_out_valid && (state != ST_WAIT);
  assign wd_en     = (state == ST_WAIT);
  assign wd_clr    = (state != ST_WAIT) || tc_out_valid;

  tc_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (wd_clr),
    .en     (wd_en),
    .expire (wd_expire)
  );

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (cmd_fire) begin
          state_nx = (cmd_k == '0) ? ST_RESULT : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (ab_fire) begin
          state_nx = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (tc_out_valid) begin
          state_nx = last_step ? ST_RESULT : ST_ISSUE;
        end else if (wd_expire) begin
          state_nx = ST_IDLE;
        end
      end
      ST_RESULT: begin
        if (res_fire) begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Handshake and status outputs are registered from the next state so they
  // line up with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cmd_ready <= 1'b1;
      ab_ready  <= 1'b0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      cmd_ready <= (state_nx == ST_IDLE);
      ab_ready  <= (state_nx == ST_ISSUE);
      res_valid <= (state_nx == ST_RESULT);
      busy      <= (state_nx != ST_IDLE);
    end
  end

  // quiet masks results still draining out of the core after a reset abort;
  // it lifts once a fresh command has been accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err   <= 1'b0;
      quiet <= 1'b1;
    end else begin
      if (cmd_fire) begin
        err   <= 1'b0;
        quiet <= 1'b0;
      end else if (wd_expire || (stray && !quiet)) begin
        err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tc_in_valid <= 1'b0;
    end else begin
      tc_in_valid <= ab_fire;
    end
  end

  // Operand, accumulator and result registers; only one of the three update
  // sources can be active in a given state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_reg       <= '0;
      step_cnt    <= '0;
      acc         <= '0;
      tc_e5m2mode <= 1'b0;
      tc_a        <= '0;
      tc_b        <= '0;
      tc_c        <= '0;
      res_d       <= '0;
    end else begin
      if (cmd_fire) begin
        k_reg       <= cmd_k;
        acc         <= cmd_c;
        tc_e5m2mode <= cmd_e5m2;
        step_cnt    <= '0;
        if (cmd_k == '0) begin
          res_d <= cmd_c;
        end
      end
      if (ab_fire) begin
        tc_a     <= ab_a;
        tc_b     <= ab_b;
        tc_c     <= acc;
        step_cnt <= step_cnt + KW'(1);
      end
      if ((state == ST_WAIT) && tc_out_valid) begin
        acc <= tc_d;
        if (last_step) begin
          res_d <= tc_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_tc_accum_sequencer.sv
// Scoreboard bench for tc_accum_sequencer with a latency-5 XOR tensorcore stub.
module tb_tc_accum_sequencer;

  localparam int DW = 256;
  localparam int KW = 8;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] c;
    logic          m;
  } tc_exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [KW-1:0] cmd_k = '0;
  logic          cmd_e5m2 = 1'b0;
  logic [DW-1:0] cmd_c = '0;
  logic          ab_valid = 1'b0;
  logic          ab_ready;
  logic [DW-1:0] ab_a = '0;
  logic [DW-1:0] ab_b = '0;
  logic          tc_in_valid;
  logic          tc_e5m2mode;
  logic [DW-1:0] tc_a;
  logic [DW-1:0] tc_b;
  logic [DW-1:0] tc_c;
  logic          tc_out_valid;
  logic [DW-1:0] tc_d;
  logic          res_valid;
  logic          res_ready = 1'b1;
  logic [DW-1:0] res_d;
  logic          busy;
  logic          err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int busy_gap = 0;
  logic busy_watch = 1'b0;
  int pulse_cyc[$];
  tc_exp_t tc_q[$];
  logic [DW-1:0] res_q[$];
  tc_exp_t tc_e;
  logic [DW-1:0] res_e;

  logic          mute = 1'b0;
  logic          stray = 1'b0;
  logic [DW-1:0] stray_d = '0;
  logic [4:0]    stub_v = '0;
  logic [DW-1:0] stub_d [5];

  always #5 clk = ~clk;

  tc_accum_sequencer #(.DW(DW), .KW(KW), .TIMEOUT(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_k        (cmd_k),
    .cmd_e5m2     (cmd_e5m2),
    .cmd_c        (cmd_c),
    .ab_valid     (ab_valid),
    .ab_ready     (ab_ready),
    .ab_a         (ab_a),
    .ab_b         (ab_b),
    .tc_in_valid  (tc_in_valid),
    .tc_e5m2mode  (tc_e5m2mode),
    .tc_a         (tc_a),
    .tc_b         (tc_b),
    .tc_c         (tc_c),
    .tc_out_valid (tc_out_valid),
    .tc_d         (tc_d),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_d        (res_d),
    .busy         (busy),
    .err          (err)
  );

  // Tensorcore stub: d = a ^ b ^ c, five cycles after the issue pulse.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    stub_v <= {stub_v[3:0], tc_in_valid && !mute};
    stub_d[0] <= tc_a ^ tc_b ^ tc_c;
    for (int i = 1; i < 5; i++) stub_d[i] <= stub_d[i-1];
  end
  assign tc_out_valid = stub_v[4] | stray;
  assign tc_d = stray ? stray_d : stub_d[4];

  function automatic void check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endfunction

  function automatic void timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired waiting for DUT", name);
  endfunction

  // Monitor: every issue pulse must match the next expected operand set.
  always @(negedge clk) begin
    if (rst && tc_in_valid) begin
      pulse_cnt++;
      pulse_cyc.push_back(cyc);
      if (tc_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tc_unexpected: pulse with tc_a=%0h, required no pulse", tc_a);
      end else begin
        tc_e = tc_q.pop_front();
        check("tc_a", tc_a, tc_e.a);
        check("tc_b", tc_b, tc_e.b);
        check("tc_c", tc_c, tc_e.c);
        check("tc_e5m2mode", {255'd0, tc_e5m2mode}, {255'd0, tc_e.m});
      end
    end
    if (busy_watch && !busy) busy_gap++;
  end

  // Monitor: every result handshake must match the next expected tile.
  always @(negedge clk) begin
    if (rst && res_valid && res_ready) begin
      if (res_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL res_unexpected: res_d=%0h, required no result", res_d);
      end else begin
        res_e = res_q.pop_front();
        check("res_d", res_d, res_e);
      end
    end
  end

  task automatic issue_cmd(input int k, input logic m, input logic [DW-1:0] c);
    bit done = 0;
    cmd_k = KW'(k);
    cmd_e5m2 = m;
    cmd_c = c;
    cmd_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (cmd_ready) done = 1;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    if (!done) timeout_fail("cmd_accept");
  endtask

  task automatic send_ab(input logic [DW-1:0] a, input logic [DW-1:0] b);
    bit done = 0;
    ab_a = a;
    ab_b = b;
    ab_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (ab_ready) done = 1;
    end
    @(posedge clk);
    #1;
    ab_valid = 1'b0;
    if (!done) timeout_fail("ab_accept");
  endtask

  task automatic wait_res(input int max_cyc);
    bit done = 0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      @(negedge clk);
      if (res_valid && res_ready) done = 1;
    end
    @(posedge clk);
    #1;
    if (!done) timeout_fail("res_fire");
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_cmd_ready"}, {255'd0, cmd_ready}, 256'd1);
    check({tag, "_ab_ready"}, {255'd0, ab_ready}, 256'd0);
    check({tag, "_tc_in_valid"}, {255'd0, tc_in_valid}, 256'd0);
    check({tag, "_tc_e5m2mode"}, {255'd0, tc_e5m2mode}, 256'd0);
    check({tag, "_tc_a"}, tc_a, 256'd0);
    check({tag, "_tc_b"}, tc_b, 256'd0);
    check({tag, "_tc_c"}, tc_c, 256'd0);
    check({tag, "_res_valid"}, {255'd0, res_valid}, 256'd0);
    check({tag, "_res_d"}, res_d, 256'd0);
    check({tag, "_busy"}, {255'd0, busy}, 256'd0);
    check({tag, "_err"}, {255'd0, err}, 256'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int n0;
    int base;
    int n_err;
    bit seen;

    // Power-on reset
    #3 rst = 1'b0;
    #2;
    check_idle_outputs("por");
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;

    // k = 0: the initial C is the result, no tensorcore traffic
    n0 = pulse_cnt;
    res_q.push_back(256'h1234);
    issue_cmd(0, 1'b0, 256'h1234);
    check("k0_res_valid", {255'd0, res_valid}, 256'd1);
    check("k0_res_d_early", res_d, 256'h1234);
    wait_res(20);
    check("k0_no_pulse", pulse_cnt, n0);
    check("k0_cmd_ready_after", {255'd0, cmd_ready}, 256'd1);

    // k = 1: 1 ^ 2 ^ 4 = 7, FP8 mode carried to the core
    n0 = pulse_cnt;
    tc_q.push_back('{a: 256'h2, b: 256'h4, c: 256'h1, m: 1'b1});
    res_q.push_back(256'h7);
    issue_cmd(1, 1'b1, 256'h1);
    send_ab(256'h2, 256'h4);
    wait_res(50);
    check("k1_pulses", pulse_cnt, n0 + 1);

    // k = 3 chain: C sequence 0, 3, 15 and final 63
    n0 = pulse_cnt;
    base = pulse_cyc.size();
    tc_q.push_back('{a: 256'h1, b: 256'h2, c: 256'h0, m: 1'b0});
    tc_q.push_back('{a: 256'h4, b: 256'h8, c: 256'h3, m: 1'b0});
    tc_q.push_back('{a: 256'h10, b: 256'h20, c: 256'hf, m: 1'b0});
    res_q.push_back(256'd63);
    issue_cmd(3, 1'b0, 256'h0);
    busy_gap = 0;
    busy_watch = 1'b1;
    send_ab(256'h1, 256'h2);
    send_ab(256'h4, 256'h8);
    send_ab(256'h10, 256'h20);
    wait_res(100);
    busy_watch = 1'b0;
    check("k3_pulses", pulse_cnt, n0 + 3);
    if (pulse_cyc.size() >= base + 3) begin
      check("k3_spacing_1", pulse_cyc[base+1] - pulse_cyc[base], 7);
      check("k3_spacing_2", pulse_cyc[base+2] - pulse_cyc[base+1], 7);
    end else begin
      timeout_fail("k3_spacing");
    end
    check("k3_busy_gap", busy_gap, 0);

    // Backpressure on operands and on the result
    n0 = pulse_cnt;
    res_ready = 1'b0;
    tc_q.push_back('{a: 256'h1, b: 256'h2, c: 256'h10, m: 1'b0});
    tc_q.push_back('{a: 256'h4, b: 256'h8, c: 256'h13, m: 1'b0});
    res_q.push_back(256'h1f);
    issue_cmd(2, 1'b0, 256'h10);
    repeat (10) @(negedge clk);
    check("bp_stall_ab_ready", {255'd0, ab_ready}, 256'd1);
    check("bp_stall_no_pulse", pulse_cnt, n0);
    @(posedge clk);
    #1;
    send_ab(256'h1, 256'h2);
    send_ab(256'h4, 256'h8);
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (res_valid) seen = 1;
    end
    if (!seen) timeout_fail("bp_res_valid");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_hold_valid", {255'd0, res_valid}, 256'd1);
      check("bp_hold_d", res_d, 256'h1f);
      check("bp_hold_cmd_ready", {255'd0, cmd_ready}, 256'd0);
    end
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    wait_res(5);
    check("bp_cmd_ready_after", {255'd0, cmd_ready}, 256'd1);
    check("bp_res_valid_after", {255'd0, res_valid}, 256'd0);
    check("bp_pulses", pulse_cnt, n0 + 2);

    // Muted core: watchdog fires 64 cycles after the issue pulse
    mute = 1'b1;
    tc_q.push_back('{a: 256'h1, b: 256'h1, c: 256'h5, m: 1'b0});
    issue_cmd(1, 1'b0, 256'h5);
    send_ab(256'h1, 256'h1);
    n_err = -1;
    for (int i = 1; i <= 100 && n_err < 0; i++) begin
      @(posedge clk);
      #1;
      if (err) n_err = i;
    end
    check("to_err_cycles", n_err, 64);
    check("to_idle_cmd_ready", {255'd0, cmd_ready}, 256'd1);
    check("to_idle_busy", {255'd0, busy}, 256'd0);
    check("to_no_result", {255'd0, res_valid}, 256'd0);
    mute = 1'b0;

    // Next command clears err
    res_q.push_back(256'habc);
    issue_cmd(0, 1'b0, 256'habc);
    check("cmd_clears_err", {255'd0, err}, 256'd0);
    wait_res(20);

    // Stray result in IDLE sets err, state stays IDLE
    stray_d = 256'hdead;
    stray = 1'b1;
    @(posedge clk);
    #1;
    stray = 1'b0;
    check("stray_idle_err", {255'd0, err}, 256'd1);
    check("stray_idle_cmd_ready", {255'd0, cmd_ready}, 256'd1);
    check("stray_idle_busy", {255'd0, busy}, 256'd0);

    // Stray result in ISSUE sets err but leaves acc feeding tc_c
    tc_q.push_back('{a: 256'h1, b: 256'h2, c: 256'h55, m: 1'b0});
    res_q.push_back(256'h56);
    issue_cmd(1, 1'b0, 256'h55);
    check("stray_issue_pre_err", {255'd0, err}, 256'd0);
    stray_d = 256'hbeef;
    stray = 1'b1;
    @(posedge clk);
    #1;
    stray = 1'b0;
    check("stray_issue_err", {255'd0, err}, 256'd1);
    check("stray_issue_ab_ready", {255'd0, ab_ready}, 256'd1);
    send_ab(256'h1, 256'h2);
    wait_res(50);

    // Async reset in WAIT, with a result still in flight in the stub
    tc_q.push_back('{a: 256'h3, b: 256'h9, c: 256'h7, m: 1'b1});
    issue_cmd(1, 1'b1, 256'h7);
    send_ab(256'h3, 256'h9);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("rst_pre_busy", {255'd0, busy}, 256'd1);
    rst = 1'b0;
    #1;
    check_idle_outputs("rst_wait");
    @(posedge clk);
    #1;
    @(negedge clk) rst = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("rst_late_err", {255'd0, err}, 256'd0);
    check("rst_late_res_valid", {255'd0, res_valid}, 256'd0);
    check("rst_late_busy", {255'd0, busy}, 256'd0);

    check("tc_q_drained", tc_q.size(), 0);
    check("res_q_drained", res_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
